// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// counter widths, SRAM timeout default and the EXE_CMD opcode constants.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERR     = 2'd2
  } hz_state_e;

  localparam int SRAM_TIMEOUT_DEF = 255;
  localparam int WAIT_CNT_W       = 8;
  localparam int STALL_CNT_W      = 16;

  // EXE_CMD values driven by the control unit into the ALU
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMP = 4'b0100;
  localparam logic [3:0] EXE_TST = 4'b0110;
  localparam logic [3:0] EXE_LDR = 4'b0010;
  localparam logic [3:0] EXE_STR = 4'b0010;

endpackage

// File: rtl/raw_detect.sv
// Combinational read-after-write detection between the ID instruction and
// the destinations still in flight in EXE and MEM.
module raw_detect (
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_reads_rn,
  input  logic       id_two_src,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [3:0] exe_dest,
  input  logic       mem_wb_en,
  input  logic [3:0] mem_dest,
  input  logic       forward_en,
  output logic       raw
);

  logic exe_hit1;
  logic exe_hit2;
  logic mem_hit1;
  logic mem_hit2;
  logic exe_hit;
  logic mem_hit;
  logic load_use;

  // Register 0 is an ordinary register here, so every number compares.
  assign exe_hit1 = id_reads_rn & (id_src1 == exe_dest);
  assign exe_hit2 = id_two_src  & (id_src2 == exe_dest);
  assign mem_hit1 = id_reads_rn & (id_src1 == mem_dest);
  assign mem_hit2 = id_two_src  & (id_src2 == mem_dest);

  assign exe_hit  = exe_wb_en & (exe_hit1 | exe_hit2);
  assign mem_hit  = mem_wb_en & (mem_hit1 | mem_hit2);
  assign load_use = exe_hit & exe_mem_r_en;

  // With forwarding only a load result is unavailable in time.
  assign raw = forward_en ? load_use : (exe_hit | mem_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, RAW bubbles, SRAM wait freeze
// with timeout, and stall/error statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int SRAM_TIMEOUT = SRAM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_reads_rn,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic        exe_b,
  input  logic [3:0]  exe_dest,
  input  logic        mem_wb_en,
  input  logic [3:0]  mem_dest,
  input  logic        forward_en,
  input  logic        sram_req,
  input  logic        sram_ready,
  input  logic        clr_stats,
  output logic        freeze_if,
  output logic        flush_if,
  output logic        flush_id,
  output logic        freeze_pipe,
  output logic [15:0] stall_cycles,
  output logic        sram_err,
  output logic [1:0]  state
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(SRAM_TIMEOUT - 1);

  hz_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   sram_err_q, sram_err_d;

  logic raw;
  logic mem_stall;
  logic freeze_if_c;
  logic flush_if_c;
  logic flush_id_c;
  logic freeze_pipe_c;

  raw_detect u_raw_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_reads_rn  (id_reads_rn),
    .id_two_src   (id_two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .forward_en   (forward_en),
    .raw          (raw)
  );

  assign mem_stall = sram_req & ~sram_ready;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_d       = stall_q;
    sram_err_d    = sram_err_q;
    freeze_if_c   = 1'b0;
    flush_if_c    = 1'b0;
    flush_id_c    = 1'b0;
    freeze_pipe_c = 1'b0;

    case (state_q)
      ST_RUN: begin
        freeze_pipe_c = mem_stall;
        if (exe_b) begin
          flush_if_c = 1'b1;
          flush_id_c = 1'b1;
        end else if (raw) begin
          freeze_if_c = 1'b1;
          flush_id_c  = 1'b1;
        end
        if (mem_stall) begin
          state_d    = ST_MEMWAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEMWAIT: begin
        // The ready cycle releases the back end; IF stays held one more cycle.
        freeze_if_c   = 1'b1;
        freeze_pipe_c = ~sram_ready;
        if (sram_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_ERR;
          sram_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        freeze_if_c   = 1'b1;
        freeze_pipe_c = 1'b1;
        if (clr_stats) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (freeze_if_c && (stall_q != '1)) stall_d = stall_q + 1'b1;

    if (clr_stats) begin
      stall_d    = '0;
      sram_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      sram_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      sram_err_q <= sram_err_d;
    end
  end

  // Reset forces the decoded controls low so no freeze escapes while held.
  assign freeze_if    = rst & freeze_if_c;
  assign flush_if     = rst & flush_if_c;
  assign flush_id     = rst & flush_id_c;
  assign freeze_pipe  = rst & freeze_pipe_c;
  assign stall_cycles = stall_q;
  assign sram_err     = sram_err_q;
  assign state        = state_q;

endmodule
